key_conditioner: RTL and testbench

//  Upstream input stage of lab1: turns raw, bouncing, active-low DE2-115 push keys

---
 rtl/key_cond_pkg.sv | 47 ++++
 rtl/key_debounce_ch.sv | 189 ++++++++++++++++++
 rtl/key_conditioner.sv | 47 ++++
 tb/tb_key_conditioner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// -----------------------------------------------------------------------------
// key_cond_pkg
//   Shared types and width helpers for the push-key conditioner.
//   - key_state_e : per-channel debounce / long-press state
//   - deb_cnt_w   : width of the debounce counter
//   - hold_cnt_w  : width of the shared hold / repeat counter width
//   - state_is_down : decode of the debounced level from a channel state
// -----------------------------------------------------------------------------
package key_cond_pkg;

    typedef enum logic [2:0] {
        S_UP     = 3'd0,
        S_DN_CHK = 3'd1,
        S_DOWN   = 3'd2,
        S_HELD   = 3'd3,
        S_UP_CHK = 3'd4
    } key_state_e;

    // Raw key level that means "released" (keys are active-low).
    localparam logic KEY_RELEASED = 1'b1;

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    function automatic int deb_cnt_w(input int debounce_cycles);
        if (debounce_cycles < 2) begin
            return 1;
        end
        return $clog2(debounce_cycles);
    endfunction

    // Hold and repeat counters share one width so they can never overflow
    // whichever of the two periods is longer.
    function automatic int hold_cnt_w(input int hold_cycles, input int repeat_cycles);
        int m;
        m = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
        if (m < 2) begin
            m = 2;
        end
        return $clog2(m);
    endfunction

    // Debounced level is high while the key is considered pressed, which
    // includes the window where a release is still being confirmed.
    function automatic logic state_is_down(input key_state_e st);
        return (st == S_DOWN) || (st == S_HELD) || (st == S_UP_CHK);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
//   One push-key channel: 2-flop synchroniser, debounce FSM, long-press and
//   auto-repeat detection. All outputs are registered.
// Ports
//   i_clk      in  system clock
//   i_rst_n    in  asynchronous active-low reset
//   i_key_n    in  raw key, 0 = pressed, asynchronous to i_clk
//   o_level    out debounced level, 1 = pressed
//   o_press    out 1-cycle pulse on debounced press
//   o_release  out 1-cycle pulse on debounced release
//   o_hold     out 1-cycle pulse at long-press and every repeat interval
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 12_500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    localparam int DEB_W  = deb_cnt_w(DEBOUNCE_CYCLES);
    localparam int HOLD_W = hold_cnt_w(HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  =
        HOLD_W'((REPEAT_CYCLES == 0) ? 0 : (REPEAT_CYCLES - 1));

    // Synchroniser
    logic r_sync1;
    logic r_sync2;
    logic w_sync_n;

    // FSM state and counters
    key_state_e        r_state;
    key_state_e        w_state_next;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [DEB_W-1:0]  w_deb_cnt_next;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_next;
    logic [HOLD_W-1:0] r_rep_cnt;
    logic [HOLD_W-1:0] w_rep_cnt_next;
    logic              r_was_held;
    logic              w_was_held_next;

    // Registered outputs
    logic r_level;
    logic r_press;
    logic r_release;
    logic r_hold;
    logic w_press_next;
    logic w_release_next;
    logic w_hold_next;

    // Synchroniser flops reset to "released" so a key held through reset is
    // seen as a fresh press once reset lifts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= KEY_RELEASED;
            r_sync2 <= KEY_RELEASED;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sync_n = r_sync2;

    // State, counters and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_UP;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_was_held <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_deb_cnt  <= w_deb_cnt_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_rep_cnt  <= w_rep_cnt_next;
            r_was_held <= w_was_held_next;
            r_level    <= state_is_down(w_state_next);
            r_press    <= w_press_next;
            r_release  <= w_release_next;
            r_hold     <= w_hold_next;
        end
    end

    // Next-state and pulse logic. Each counter is compared against its last
    // value before incrementing, so it never leaves its range.
    always_comb begin
        w_state_next    = r_state;
        w_deb_cnt_next  = r_deb_cnt;
        w_hold_cnt_next = r_hold_cnt;
        w_rep_cnt_next  = r_rep_cnt;
        w_was_held_next = r_was_held;
        w_press_next    = 1'b0;
        w_release_next  = 1'b0;
        w_hold_next     = 1'b0;

        case (r_state)
            S_UP: begin
                if (!w_sync_n) begin
                    w_state_next   = S_DN_CHK;
                    w_deb_cnt_next = '0;
                end
            end

            S_DN_CHK: begin
                if (w_sync_n) begin
                    // Bounce before the press was confirmed: silently drop it.
                    w_state_next = S_UP;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_next    = S_DOWN;
                    w_press_next    = 1'b1;
                    w_hold_cnt_next = '0;
                end else begin
                    w_deb_cnt_next = r_deb_cnt + DEB_W'(1);
                end
            end

            S_DOWN: begin
                if (w_sync_n) begin
                    w_state_next    = S_UP_CHK;
                    w_was_held_next = 1'b0;
                    w_deb_cnt_next  = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next   = S_HELD;
                    w_hold_next    = 1'b1;
                    w_rep_cnt_next = '0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
                end
            end

            S_HELD: begin
                if (w_sync_n) begin
                    w_state_next    = S_UP_CHK;
                    w_was_held_next = 1'b1;
                    w_deb_cnt_next  = '0;
                end else if (REPEAT_CYCLES != 0) begin
                    if (r_rep_cnt == REP_LAST) begin
                        w_hold_next    = 1'b1;
                        w_rep_cnt_next = '0;
                    end else begin
                        w_rep_cnt_next = r_rep_cnt + HOLD_W'(1);
                    end
                end
            end

            S_UP_CHK: begin
                // Hold/repeat counters stay frozen here so a release bounce
                // only delays, and never restarts, long-press timing.
                if (!w_sync_n) begin
                    w_state_next = r_was_held ? S_HELD : S_DOWN;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_next   = S_UP;
                    w_release_next = 1'b1;
                end else begin
                    w_deb_cnt_next = r_deb_cnt + DEB_W'(1);
                end
            end

            default: begin
                w_state_next = S_UP;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_hold    = r_hold;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//   Input stage for the DE2-115 push keys: converts raw, bouncing, active-low
//   keys into clean single-cycle events. One independent channel per key.
// Ports
//   i_clk      in  system clock (50 MHz)
//   i_rst_n    in  asynchronous active-low reset
//   i_key_n    in  [NUM_KEYS] raw keys, 0 = pressed
//   o_level    out [NUM_KEYS] debounced level, 1 = pressed
//   o_press    out [NUM_KEYS] 1-cycle pulse on debounced press
//   o_release  out [NUM_KEYS] 1-cycle pulse on debounced release
//   o_hold     out [NUM_KEYS] 1-cycle pulse at long-press and each repeat
// -----------------------------------------------------------------------------
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 12_500_000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_KEYS-1:0] i_key_n,
    output logic [NUM_KEYS-1:0] o_level,
    output logic [NUM_KEYS-1:0] o_press,
    output logic [NUM_KEYS-1:0] o_release,
    output logic [NUM_KEYS-1:0] o_hold
);

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_key_n   (i_key_n[gi]),
            .o_level   (o_level[gi]),
            .o_press   (o_press[gi]),
            .o_release (o_release[gi]),
            .o_hold    (o_hold[gi])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_HOLD  = 2;

    typedef struct {
        int         cyc;
        logic [1:0] key;
        int         kind;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_n;
    logic [3:0] o_level;
    logic [3:0] o_press;
    logic [3:0] o_release;
    logic [3:0] o_hold;

    int   edge_cnt = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;
    ev_t  sb[$];

    logic [3:0] exp_level = 4'h0;
    logic [3:0] m_ep;
    logic [3:0] m_er;
    logic [3:0] m_eh;

    key_conditioner #(
        .NUM_KEYS        (4),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (8)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_key_n   (key_n),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release),
        .o_hold    (o_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got=%0h exp=%0h", tag, edge_cnt, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Next drive is sampled at edge t.
    task automatic wait_until(input int t);
        while (edge_cnt + 1 < t) tick(1);
    endtask

    task automatic drive(input logic [1:0] k, input logic v, output int e);
        key_n[k] = v;
        e = edge_cnt + 1;
    endtask

    task automatic push(input int cyc, input logic [1:0] k, input int kind);
        ev_t ev;
        ev.cyc  = cyc;
        ev.key  = k;
        ev.kind = kind;
        sb.push_back(ev);
    endtask

    // Monitor: outputs at this negedge reflect posedge number edge_cnt.
    always @(negedge clk) begin
        if (mon_en) begin
            m_ep = 4'h0;
            m_er = 4'h0;
            m_eh = 4'h0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == edge_cnt) begin
                    case (sb[i].kind)
                        K_PRESS: begin m_ep[sb[i].key] = 1'b1; exp_level[sb[i].key] = 1'b1; end
                        K_REL:   begin m_er[sb[i].key] = 1'b1; exp_level[sb[i].key] = 1'b0; end
                        default: m_eh[sb[i].key] = 1'b1;
                    endcase
                    sb.delete(i);
                end else if (sb[i].cyc < edge_cnt) begin
                    check("sb_late", 32'(sb[i].cyc), 32'(edge_cnt));
                    sb.delete(i);
                end
            end
            check("press",   32'(o_press),   32'(m_ep));
            check("release", 32'(o_release), 32'(m_er));
            check("hold",    32'(o_hold),    32'(m_eh));
            check("level",   32'(o_level),   32'(exp_level));
            $display("[TB] edge %0d lvl=%h prs=%h rel=%h hld=%h", edge_cnt, o_level, o_press, o_release, o_hold);
        end
    end

    initial begin
        int e;
        int e3;
        int p;
        int r;
        int t;

        rst_n = 1'b0;
        key_n = 4'hF;
        tick(3);
        check("rst_level",   32'(o_level),   32'h0);
        check("rst_press",   32'(o_press),   32'h0);
        check("rst_release", 32'(o_release), 32'h0);
        check("rst_hold",    32'(o_hold),    32'h0);

        // Idle after reset: nothing may happen.
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick(50);

        // Clean press on key0, then clean release.
        drive(2'd0, 1'b0, e);
        push(e + 6, 2'd0, K_PRESS);
        tick(15);
        drive(2'd0, 1'b1, e);
        push(e + 6, 2'd0, K_REL);
        tick(12);

        // Press bounce: 3 cycles low is too short.
        drive(2'd0, 1'b0, e);
        tick(3);
        drive(2'd0, 1'b1, e3);
        tick(12);

        // Stable press, then a short release bounce, then a real release.
        drive(2'd0, 1'b0, e);
        p = e + 6;
        push(p, 2'd0, K_PRESS);
        wait_until(p + 2);
        drive(2'd0, 1'b1, e);
        tick(2);
        drive(2'd0, 1'b0, e);
        wait_until(p + 10);
        drive(2'd0, 1'b1, e);
        push(e + 6, 2'd0, K_REL);
        tick(12);

        // Long hold on key2 with auto-repeat.
        drive(2'd2, 1'b0, e);
        p = e + 6;
        push(p, 2'd2, K_PRESS);
        r = p + 60;
        for (t = p + 20; t <= r + 1; t += 8) push(t, 2'd2, K_HOLD);
        wait_until(r);
        drive(2'd2, 1'b1, e);
        push(e + 6, 2'd2, K_REL);
        tick(12);

        // key1 and key3 together, reset asserted while held.
        drive(2'd1, 1'b0, e);
        drive(2'd3, 1'b0, e);
        p = e + 6;
        push(p, 2'd1, K_PRESS);
        push(p, 2'd3, K_PRESS);
        push(p + 20, 2'd1, K_HOLD);
        push(p + 20, 2'd3, K_HOLD);
        wait_until(p + 24);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("mid_rst_level",   32'(o_level),   32'h0);
        check("mid_rst_press",   32'(o_press),   32'h0);
        check("mid_rst_release", 32'(o_release), 32'h0);
        check("mid_rst_hold",    32'(o_hold),    32'h0);
        sb.delete();
        exp_level = 4'h0;
        tick(3);

        // Keys still held as reset lifts: one fresh press each.
        rst_n  = 1'b1;
        mon_en = 1'b1;
        p = edge_cnt + 1 + 6;
        push(p, 2'd1, K_PRESS);
        push(p, 2'd3, K_PRESS);
        push(p + 20, 2'd1, K_HOLD);
        push(p + 20, 2'd3, K_HOLD);
        push(p + 28, 2'd1, K_HOLD);
        push(p + 28, 2'd3, K_HOLD);
        wait_until(p + 30);
        drive(2'd1, 1'b1, e);
        drive(2'd3, 1'b1, e);
        push(e + 6, 2'd1, K_REL);
        push(e + 6, 2'd3, K_REL);
        tick(12);

        mon_en = 1'b0;
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
